// File: rtl/gerador_diferenca_pkg.sv
// -----------------------------------------------------------------------------
// gerador_diferenca_pkg
// Shared definitions for the guessing-game compare front end:
//   - value / difference widths
//   - default round parameters
//   - FSM state encoding and the debug view exported by the top level
//   - helper that forms the 5-bit wrapped difference (attempt - secret)
// -----------------------------------------------------------------------------
package gerador_diferenca_pkg;

  localparam int VAL_W               = 4;  // width of secret and attempt
  localparam int DIF_W               = 5;  // sign bit + 4-bit two's complement
  localparam int MAX_TENTATIVAS_DEF  = 5;
  localparam int DEBOUNCE_CICLOS_DEF = 4;

  typedef enum logic [2:0] {
    AGUARDA_SENHA     = 3'd0,
    AGUARDA_TENTATIVA = 3'd1,
    COMPARA           = 3'd2,
    ACERTOU           = 3'd3,
    BLOQUEADO         = 3'd4
  } estado_t;

  // Debug view: current FSM state plus the last advisory "within 3" verdict.
  typedef struct packed {
    estado_t estado;
    logic    ate3;
  } dbg_t;

  // Both operands are zero-extended so bit 4 of the result is the sign of the
  // true difference for the whole -15..+15 range.
  function automatic logic [DIF_W-1:0] calc_diferenca(
    input logic [VAL_W-1:0] tentativa,
    input logic [VAL_W-1:0] senha
  );
    return {1'b0, tentativa} - {1'b0, senha};
  endfunction

endpackage

// File: rtl/gerador_diferenca_detector_borda.sv
// -----------------------------------------------------------------------------
// detector_borda
// Rising-edge pulse generator for the confirm button, with an optional
// debounce filter in front of it.
//
// Configuration macro: DEBOUNCE_EN
//   defined   : the level must be stable for DEBOUNCE_CICLOS consecutive
//               samples before the filtered level follows it
//   undefined : the raw level feeds the edge detector directly
//
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-high
//   i_nivel  in  button level (already synchronous to clk)
//   o_pulso  out high for one cycle when the (filtered) level goes 0 -> 1
// -----------------------------------------------------------------------------
module detector_borda #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_nivel,
  output logic o_pulso
);

  logic w_nivel;
  logic r_anterior;

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_filtrado;

  // r_cnt counts consecutive samples that disagree with the filtered level;
  // the DEBOUNCE_CICLOS-th disagreeing sample flips the filtered level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_filtrado <= 1'b0;
    end else if (i_nivel != r_filtrado) begin
      if (r_cnt == CNT_W'(DEBOUNCE_CICLOS - 1)) begin
        r_filtrado <= i_nivel;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_nivel = r_filtrado;
`else
  assign w_nivel = i_nivel;
`endif

  // The previous-level register always tracks the button, even while the
  // FSM ignores presses, so a held button never produces a late pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_anterior <= 1'b0;
    else       r_anterior <= w_nivel;
  end

  assign o_pulso = w_nivel & ~r_anterior;

  generate
    if (DEBOUNCE_CICLOS < 1) begin : g_param_invalido
      $error("detector_borda: DEBOUNCE_CICLOS must be at least 1");
    end
  endgenerate

endmodule

// File: rtl/gerador_diferenca.sv
// -----------------------------------------------------------------------------
// gerador_diferenca
// Sequential front end of the guessing game's compare path. Latches the
// secret, accepts one attempt per confirm press, presents the signed
// difference (attempt - secret) to the downstream comparator, samples its
// verdict one cycle later, counts attempts and locks the round on a hit or
// when the attempt limit is reached.
//
// Configuration macro: DEBOUNCE_EN (debounce filter on confirmar, see
// detector_borda).
//
// Handshake: valido is a one-cycle strobe, high in the cycle after an accepted
// press; diff/sinal are valid in that cycle and hold until the next accepted
// attempt. The comparator answers on igual_in/ate3_in within that same cycle.
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous, active-high, clears all state
//   senha_in[3:0]   in   secret value
//   carregar_senha  in   latch secret and start a new round (wins over a press)
//   tentativa_in    in   attempt value
//   confirmar       in   attempt button level
//   igual_in        in   comparator: difference is zero
//   ate3_in         in   comparator: |difference| <= 3, non-zero (advisory)
//   diff[3:0]       out  low 4 bits of attempt - secret
//   sinal           out  bit 4 of the difference (1 = negative)
//   valido          out  strobe: new attempt on diff/sinal
//   tentativas[2:0] out  attempts consumed this round
//   acertou         out  round won
//   bloqueado       out  round lost
//   dbg             out  FSM state and last advisory verdict
// -----------------------------------------------------------------------------
module gerador_diferenca
  import gerador_diferenca_pkg::*;
#(
  parameter int MAX_TENTATIVAS  = MAX_TENTATIVAS_DEF,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] senha_in,
  input  logic             carregar_senha,
  input  logic [VAL_W-1:0] tentativa_in,
  input  logic             confirmar,
  input  logic             igual_in,
  input  logic             ate3_in,
  output logic [VAL_W-1:0] diff,
  output logic             sinal,
  output logic             valido,
  output logic [2:0]       tentativas,
  output logic             acertou,
  output logic             bloqueado,
  output dbg_t             dbg
);

  estado_t          r_estado;
  logic [VAL_W-1:0] r_senha;
  logic [VAL_W-1:0] r_diff;
  logic             r_sinal;
  logic             r_valido;
  logic [2:0]       r_tentativas;
  logic             r_acertou;
  logic             r_bloqueado;
  logic             r_ate3;

  logic             w_press;
  logic [DIF_W-1:0] w_d5;

  detector_borda #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_borda_confirmar (
    .clk     (clk),
    .reset   (reset),
    .i_nivel (confirmar),
    .o_pulso (w_press)
  );

  assign w_d5 = calc_diferenca(tentativa_in, r_senha);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado     <= AGUARDA_SENHA;
      r_senha      <= '0;
      r_diff       <= '0;
      r_sinal      <= 1'b0;
      r_valido     <= 1'b0;
      r_tentativas <= '0;
      r_acertou    <= 1'b0;
      r_bloqueado  <= 1'b0;
      r_ate3       <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      // Loading a secret overrides everything, including a press that lands
      // in the same cycle; that press is simply lost.
      if (carregar_senha) begin
        r_senha      <= senha_in;
        r_tentativas <= '0;
        r_acertou    <= 1'b0;
        r_bloqueado  <= 1'b0;
        r_ate3       <= 1'b0;
        r_estado     <= AGUARDA_TENTATIVA;
      end else begin
        case (r_estado)
          AGUARDA_TENTATIVA: begin
            if (w_press) begin
              r_sinal      <= w_d5[DIF_W-1];
              r_diff       <= w_d5[VAL_W-1:0];
              r_valido     <= 1'b1;
              r_tentativas <= r_tentativas + 3'd1;
              r_estado     <= COMPARA;
            end
          end
          COMPARA: begin
            // Verdict refers to the diff presented this cycle; ate3_in is
            // recorded for observation only and never steers the FSM.
            r_ate3 <= ate3_in;
            if (igual_in) begin
              r_acertou <= 1'b1;
              r_estado  <= ACERTOU;
            end else if (r_tentativas == 3'(MAX_TENTATIVAS)) begin
              r_bloqueado <= 1'b1;
              r_estado    <= BLOQUEADO;
            end else begin
              r_estado <= AGUARDA_TENTATIVA;
            end
          end
          ACERTOU:   r_estado <= ACERTOU;
          BLOQUEADO: r_estado <= BLOQUEADO;
          default:   r_estado <= AGUARDA_SENHA;
        endcase
      end
    end
  end

  assign diff       = r_diff;
  assign sinal      = r_sinal;
  assign valido     = r_valido;
  assign tentativas = r_tentativas;
  assign acertou    = r_acertou;
  assign bloqueado  = r_bloqueado;
  assign dbg        = {r_estado, r_ate3};

  generate
    if (MAX_TENTATIVAS < 1 || MAX_TENTATIVAS > 7) begin : g_param_invalido
      $error("gerador_diferenca: MAX_TENTATIVAS must be in 1..7");
    end
  endgenerate

endmodule

// File: tb/tb_gerador_diferenca.sv
// -----------------------------------------------------------------------------
// tb_gerador_diferenca
// Self-checking bench for gerador_diferenca. Inputs are driven and outputs
// sampled on the falling clock edge. A round-level model (secret, attempt
// count, won/lost) predicts which presses are accepted; expected differences
// go into exp_q and are popped whenever valido is seen.
// -----------------------------------------------------------------------------
module tb_gerador_diferenca;
  import gerador_diferenca_pkg::*;

  localparam int MAXT = 3;
  localparam int DB   = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT  = DB + 1;  // press onset to valido, in cycles
  localparam int HOLD = DB + 2;
  localparam int REL  = DB + 3;
`else
  localparam int LAT  = 1;
  localparam int HOLD = 2;
  localparam int REL  = 3;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] senha_in;
  logic       carregar_senha;
  logic [3:0] tentativa_in;
  logic       confirmar;
  logic       igual_in;
  logic       ate3_in;
  logic [3:0] diff;
  logic       sinal;
  logic       valido;
  logic [2:0] tentativas;
  logic       acertou;
  logic       bloqueado;
  dbg_t       dbg;

  always #5 clk = ~clk;

  gerador_diferenca #(
    .MAX_TENTATIVAS (MAXT),
    .DEBOUNCE_CICLOS(DB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .senha_in       (senha_in),
    .carregar_senha (carregar_senha),
    .tentativa_in   (tentativa_in),
    .confirmar      (confirmar),
    .igual_in       (igual_in),
    .ate3_in        (ate3_in),
    .diff           (diff),
    .sinal          (sinal),
    .valido         (valido),
    .tentativas     (tentativas),
    .acertou        (acertou),
    .bloqueado      (bloqueado),
    .dbg            (dbg)
  );

  int total = 0;
  int bad   = 0;

  // round-level reference model and scoreboard
  logic [3:0] m_secret = '0;
  bit         m_loaded = 0;
  bit         m_won    = 0;
  bit         m_lost   = 0;
  int         m_count  = 0;
  logic [4:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Acts as the downstream comparator for the attempt about to be pressed.
  task automatic drive_verdict(input logic [3:0] att);
    int d;
    d        = int'(att) - int'(m_secret);
    igual_in = m_loaded && (d == 0);
    ate3_in  = m_loaded && (d != 0) && (d >= -3) && (d <= 3);
  endtask

  task automatic load(input logic [3:0] s);
    @(negedge clk);
    senha_in       = s;
    carregar_senha = 1'b1;
    @(posedge clk);
    @(negedge clk);
    carregar_senha = 1'b0;
    m_secret = s; m_loaded = 1; m_won = 0; m_lost = 0; m_count = 0;
    exp_q.delete();
    total++;
    if ({tentativas, acertou, bloqueado, valido} !== 6'b0) begin
      bad++;
      $display("FAIL load_clear got tent=%0d ac=%b bl=%b val=%b exp 0", tentativas, acertou, bloqueado, valido);
    end
  endtask

  // Press with attempt att held for `hold` edges, then released for REL
  // edges. Reports valido count, index of first valido and of first acertou.
  task automatic press(input logic [3:0] att, input int hold, output int nv, output int kv, output int ka);
    bit         acc;
    logic [4:0] e;
    int         a, s;
    acc = m_loaded && !m_won && !m_lost;
    a = att; s = m_secret;
    if (acc) exp_q.push_back(5'((a - s) & 31));
    drive_verdict(att);
    tentativa_in = att;
    confirmar    = 1'b1;
    nv = 0; kv = -1; ka = -1;
    for (int k = 0; k < hold + REL; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valido === 1'b1) begin
        nv++;
        if (kv < 0) kv = k;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected valido got=%b_%h exp none", sinal, diff);
        end else begin
          e = exp_q.pop_front();
          if ({sinal, diff} !== e) begin
            bad++;
            $display("FAIL sb_diff att=%0d got=%b exp=%b", att, {sinal, diff}, e);
          end
        end
      end
      if (acertou === 1'b1 && ka < 0) ka = k;
      if (k == hold - 1) confirmar = 1'b0;
    end
    igual_in = 1'b0;
    ate3_in  = 1'b0;
    if (acc) begin
      m_count++;
      if (att == m_secret) m_won = 1;
      else if (m_count == MAXT) m_lost = 1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_missing got valido count=%0d exp %0d pending", nv, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (nv !== (acc ? 1 : 0)) begin
      bad++;
      $display("FAIL press_accept got nv=%0d exp=%0d", nv, acc ? 1 : 0);
    end
    total++;
    if ({tentativas, acertou, bloqueado} !== {3'(m_count), m_won, m_lost}) begin
      bad++;
      $display("FAIL round_state got tent=%0d ac=%b bl=%b exp tent=%0d ac=%b bl=%b",
               tentativas, acertou, bloqueado, m_count, m_won, m_lost);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({diff, sinal, valido, tentativas, acertou, bloqueado} !== 11'b0) begin
      bad++;
      $display("FAIL %s got diff=%h sinal=%b val=%b tent=%0d ac=%b bl=%b exp all 0",
               name, diff, sinal, valido, tentativas, acertou, bloqueado);
    end
  endtask

  task automatic test_reset();
    int nv, kv, ka;
    reset = 1'b1; senha_in = '0; carregar_senha = 1'b0; tentativa_in = '0;
    confirmar = 1'b0; igual_in = 1'b0; ate3_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_values");
    total++;
    if (dbg.estado !== AGUARDA_SENHA) begin
      bad++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg.estado, AGUARDA_SENHA);
    end
    reset = 1'b0;
    // no secret loaded yet: press must be ignored
    press(4'd7, HOLD, nv, kv, ka);
  endtask

  task automatic test_hit();
    int nv, kv, ka;
    load(4'd5);
    press(4'd5, HOLD, nv, kv, ka);
    total++;
    if (kv !== LAT - 1) begin
      bad++; $display("FAIL hit_valido_latency got=%0d exp=%0d", kv, LAT - 1);
    end
    total++;
    if (ka !== LAT) begin
      bad++; $display("FAIL hit_acertou_latency got=%0d exp=%0d", ka, LAT);
    end
    total++;
    if ({sinal, diff} !== 5'b00000 || tentativas !== 3'd1) begin
      bad++; $display("FAIL hit_values got=%b tent=%0d exp=00000 tent=1", {sinal, diff}, tentativas);
    end
  endtask

  task automatic test_neg_diffs();
    int nv, kv, ka;
    logic [3:0] atts [3];
    logic [4:0] exps [3];
    atts = '{4'd2, 4'd3, 4'd4};
    exps = '{5'b11101, 5'b11110, 5'b11111};
    load(4'd5);
    for (int i = 0; i < 3; i++) begin
      press(atts[i], HOLD, nv, kv, ka);
      total++;
      if ({sinal, diff} !== exps[i]) begin
        bad++; $display("FAIL neg_diff att=%0d got=%b exp=%b", atts[i], {sinal, diff}, exps[i]);
      end
    end
    load(4'd2);
    press(4'd15, HOLD, nv, kv, ka);
    total++;
    if ({sinal, diff} !== 5'b01101) begin
      bad++; $display("FAIL pos_diff_15m2 got=%b exp=01101", {sinal, diff});
    end
  endtask

  task automatic test_limit();
    int nv, kv, ka;
    logic [3:0] s;
    s = 4'($urandom_range(0, 15));
    load(s);
    for (int i = 0; i < MAXT; i++) press(s ^ 4'($urandom_range(1, 15)), HOLD, nv, kv, ka);
    total++;
    if (bloqueado !== 1'b1 || tentativas !== 3'(MAXT)) begin
      bad++; $display("FAIL limit_block got bl=%b tent=%0d exp bl=1 tent=%0d", bloqueado, tentativas, MAXT);
    end
    press(s, HOLD, nv, kv, ka);
    total++;
    if (nv !== 0 || tentativas !== 3'(MAXT)) begin
      bad++; $display("FAIL limit_extra_press got nv=%0d tent=%0d exp nv=0 tent=%0d", nv, tentativas, MAXT);
    end
  endtask

  task automatic test_held();
    int nv, kv, ka;
    load(4'd9);
    press(4'd1, 10, nv, kv, ka);
    total++;
    if (nv !== 1) begin
      bad++; $display("FAIL held_button got valido count=%0d exp=1", nv);
    end
  endtask

  task automatic test_load_priority();
    int nv, kv, ka;
    logic [3:0] s, ns;
    s  = 4'($urandom_range(0, 15));
    ns = 4'($urandom_range(0, 15));
    load(s);
    press(s ^ 4'd8, HOLD, nv, kv, ka);
    // load lands on the same edge as the (filtered) rising edge of the press
    tentativa_in   = 4'($urandom_range(0, 15));
    senha_in       = ns;
    confirmar      = 1'b1;
    carregar_senha = (LAT - 1 == 0);
    nv = 0;
    for (int k = 0; k < HOLD + REL; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valido === 1'b1) nv++;
      carregar_senha = (k + 1 == LAT - 1);
      if (k == HOLD - 1) confirmar = 1'b0;
    end
    carregar_senha = 1'b0;
    m_secret = ns; m_loaded = 1; m_won = 0; m_lost = 0; m_count = 0;
    total++;
    if (nv !== 0 || tentativas !== 3'd0 || acertou !== 1'b0 || bloqueado !== 1'b0) begin
      bad++; $display("FAIL load_priority got nv=%0d tent=%0d ac=%b bl=%b exp all 0", nv, tentativas, acertou, bloqueado);
    end
    // new secret must be in effect
    press(ns, HOLD, nv, kv, ka);
  endtask

  task automatic test_reset_compara();
    int nv, kv, ka;
    bit found;
    logic [3:0] s;
    s = 4'($urandom_range(0, 15));
    load(s);
    drive_verdict(s ^ 4'd1);
    tentativa_in = s ^ 4'd1;
    confirmar    = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valido === 1'b1) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL reset_compara_timeout got no valido exp valido within 20 cycles");
    end
    reset = 1'b1;
    #1;
    check_all_zero("reset_in_compara");
    @(negedge clk);
    reset     = 1'b0;
    confirmar = 1'b0;
    igual_in  = 1'b0;
    ate3_in   = 1'b0;
    m_loaded = 0; m_won = 0; m_lost = 0; m_count = 0; m_secret = '0;
    exp_q.delete();
    repeat (REL) @(negedge clk);
    press(s, HOLD, nv, kv, ka);
    total++;
    if (nv !== 0) begin
      bad++; $display("FAIL press_after_reset got nv=%0d exp=0", nv);
    end
  endtask

  task automatic test_random();
    int nv, kv, ka;
    logic [3:0] s, a;
    for (int r = 0; r < 6; r++) begin
      s = 4'($urandom_range(0, 15));
      load(s);
      for (int p = 0; p < MAXT + 1; p++) begin
        a = ($urandom_range(0, 3) == 0) ? s : 4'($urandom_range(0, 15));
        press(a, HOLD, nv, kv, ka);
      end
    end
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_glitch();
    int nv;
    load(4'd3);
    tentativa_in = 4'd3;
    confirmar    = 1'b1;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valido === 1'b1) nv++;
      if (k == 1) confirmar = 1'b0;
    end
    total++;
    if (nv !== 0 || tentativas !== 3'd0) begin
      bad++; $display("FAIL glitch got nv=%0d tent=%0d exp nv=0 tent=0", nv, tentativas);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hit();
    test_neg_diffs();
    test_limit();
    test_held();
    test_load_priority();
    test_reset_compara();
    test_random();
`ifdef DEBOUNCE_EN
    test_glitch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
